// File: rtl/blur3x3_rgb_stream_pkg.sv
`timescale 1ns/1ps
// Shared constants and read-FSM state type for the 3x3 RGB blur engine.
package blur3x3_rgb_stream_pkg;
  localparam int IMG_W         = 416;
  localparam int IMG_H         = 416;
  localparam int DATA_W        = 8;
  localparam int NUM_LB        = 4;
  localparam int BYTES_PER_ROW = 3 * IMG_W;
  localparam int PIX_W         = 3 * DATA_W;   // {R,G,B}
  localparam int CSUM_W        = DATA_W + 2;   // 3-pixel column sum
  localparam int WSUM_W        = DATA_W + 4;   // 9-pixel window sum

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ROW,
    RD_ROW_DONE,
    RD_FRAME_DONE
  } rd_state_t;
endpackage

// File: rtl/blur3x3_rgb_stream_lb.sv
`timescale 1ns/1ps
// One image line of RGB pixels: sequential write column, registered random read.
module line_buffer_rgb
  import blur3x3_rgb_stream_pkg::*;
#(
  parameter int IMG_W = blur3x3_rgb_stream_pkg::IMG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_wr_en,
  input  logic [PIX_W-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(IMG_W)-1:0] i_rd_addr,
  output logic [PIX_W-1:0]         o_rd_data,
  output logic                     o_wr_last
);
  localparam int COL_W = $clog2(IMG_W);

  logic [PIX_W-1:0] r_mem [IMG_W];
  logic [COL_W-1:0] r_wr_col;
  logic [PIX_W-1:0] r_rd_data;

  // Pulses with the write that completes the line
  assign o_wr_last = i_wr_en && (r_wr_col == COL_W'(IMG_W - 1));
  assign o_rd_data = r_rd_data;

  // Write column advances per accepted pixel and wraps at end of line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_wr_col <= '0;
    else if (i_clr)     r_wr_col <= '0;
    else if (o_wr_last) r_wr_col <= '0;
    else if (i_wr_en)   r_wr_col <= r_wr_col + COL_W'(1);
  end

  // RAM write port; contents need no reset
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_col] <= i_wr_data;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end
endmodule

// File: rtl/blur3x3_rgb_stream.sv
`timescale 1ns/1ps
// Streaming 3x3 RGB box blur: four line buffers in, R/G/B byte stream out,
// one-cycle intr whenever a finished row releases its oldest line.
module blur3x3_rgb_stream
  import blur3x3_rgb_stream_pkg::*;
#(
  parameter int IMG_W = blur3x3_rgb_stream_pkg::IMG_W,
  parameter int IMG_H = blur3x3_rgb_stream_pkg::IMG_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] imgDataR,
  input  logic [DATA_W-1:0] imgDataG,
  input  logic [DATA_W-1:0] imgDataB,
  input  logic              imgDataValid,
  output logic [DATA_W-1:0] outData,
  output logic              outDataValid,
  output logic              intr
);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int STEP_W = $clog2(IMG_W + 1);
  localparam int LINE_W = $clog2(IMG_H + 3);

  rd_state_t                          r_state, w_next;
  logic [1:0]                         r_wr_idx;
  logic [LINE_W-1:0]                  r_lines_stored, r_lines_freed, r_row;
  logic [STEP_W-1:0]                  r_step;
  logic [1:0]                         r_ph;
  logic [NUM_LB-1:0]                  w_wr_en, w_wr_last;
  logic [NUM_LB-1:0][PIX_W-1:0]       w_rd_data;
  logic                               w_rd_en;
  logic [COL_W-1:0]                   w_rd_addr;
  logic [LINE_W-1:0]                  w_occ;
  logic                               w_full, w_line_done, w_start, w_clr;
  logic                               w_row_end, w_free, w_load, w_col_in;
  logic [1:0]                         w_top_idx, w_mid_idx, w_bot_idx;
  logic [PIX_W-1:0]                   w_top_pix;
  logic [2:0][CSUM_W-1:0]             w_col;    // [channel]
  logic [2:0][2:0][CSUM_W-1:0]        r_win;    // [column][channel], [2] newest
  logic [2:0][WSUM_W-1:0]             w_sum;
  logic [2:0][DATA_W-1:0]             w_q;
  logic [2*DATA_W-1:0]                r_ser;
  logic [1:0]                         r_ser_left;

  // Buffers holding complete lines not yet released by a row
  assign w_occ       = r_lines_stored - r_lines_freed;
  assign w_full      = (w_occ >= LINE_W'(NUM_LB));
  assign w_line_done = |w_wr_last;
  assign w_clr       = (r_state == RD_FRAME_DONE);
  // Row r needs line r+1 fully stored
  assign w_start     = (r_state == RD_IDLE) && (r_lines_stored >= r_row + LINE_W'(2));
  assign w_row_end   = (r_state == RD_ROW_DONE) && (r_ph == 2'd1);
  assign w_free      = w_row_end && (r_row != '0);
  assign w_col_in    = (r_step < STEP_W'(IMG_W));
  assign w_rd_en     = (r_state == RD_ROW) && (r_ph == 2'd0) && w_col_in;
  assign w_rd_addr   = w_col_in ? COL_W'(r_step) : '0;
  assign w_load      = (r_state == RD_ROW) && (r_ph == 2'd2) && (r_step != '0);

  // Route the incoming pixel to the current write buffer unless all are occupied
  always_comb begin
    w_wr_en = '0;
    if (imgDataValid && !w_full) w_wr_en[r_wr_idx] = 1'b1;
  end

  for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
    line_buffer_rgb #(.IMG_W(IMG_W)) u_lb (
      .clk       (clk),
      .rst_n     (reset),
      .i_clr     (w_clr),
      .i_wr_en   (w_wr_en[i]),
      .i_wr_data ({imgDataR, imgDataG, imgDataB}),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data[i]),
      .o_wr_last (w_wr_last[i])
    );
  end

  // Write-side bookkeeping: buffer index and completed-line count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_idx       <= '0;
      r_lines_stored <= '0;
    end else if (w_clr) begin
      r_wr_idx       <= '0;
      r_lines_stored <= '0;
    end else if (w_line_done) begin
      r_wr_idx       <= r_wr_idx + 2'd1;
      r_lines_stored <= r_lines_stored + LINE_W'(1);
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RD_IDLE;
    else        r_state <= w_next;
  end

  // Read FSM next state: one row is IMG_W+1 three-cycle steps, then a 2-cycle tail
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RD_IDLE:       if (w_start) w_next = RD_ROW;
      RD_ROW:        if (r_ph == 2'd2 && r_step == STEP_W'(IMG_W)) w_next = RD_ROW_DONE;
      RD_ROW_DONE:   if (r_ph == 2'd1)
                       w_next = (r_row == LINE_W'(IMG_H - 1)) ? RD_FRAME_DONE : RD_IDLE;
      RD_FRAME_DONE: w_next = RD_IDLE;
      default:       w_next = RD_IDLE;
    endcase
  end

  // Step (column fetched) and phase (byte slot) counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step <= '0;
      r_ph   <= '0;
    end else begin
      unique case (r_state)
        RD_ROW: begin
          if (r_ph == 2'd2) begin
            r_ph   <= '0;
            r_step <= r_step + STEP_W'(1);
          end else begin
            r_ph   <= r_ph + 2'd1;
          end
        end
        RD_ROW_DONE: r_ph <= (r_ph == 2'd1) ? 2'd0 : r_ph + 2'd1;
        default: begin
          r_step <= '0;
          r_ph   <= '0;
        end
      endcase
    end
  end

  // Row counter, line release and interrupt; row 0 releases nothing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row         <= '0;
      r_lines_freed <= '0;
      intr          <= 1'b0;
    end else begin
      intr <= w_free;
      if (w_clr) begin
        r_row         <= '0;
        r_lines_freed <= '0;
      end else if (w_row_end) begin
        r_row <= r_row + LINE_W'(1);
        if (w_free) r_lines_freed <= r_lines_freed + LINE_W'(1);
      end
    end
  end

  // Line k lives in buffer k mod 4; line -1 of row 0 is virtual zero
  assign w_mid_idx = r_row[1:0];
  assign w_top_idx = r_row[1:0] - 2'd1;
  assign w_bot_idx = r_row[1:0] + 2'd1;
  assign w_top_pix = (r_row == '0) ? '0 : w_rd_data[w_top_idx];

  // Vertical 3-pixel sum per channel; column IMG_W is horizontal padding
  always_comb begin
    w_col = '0;
    if (w_col_in) begin
      for (int ch = 0; ch < 3; ch++) begin
        w_col[ch] = CSUM_W'(w_top_pix[PIX_W-1-ch*DATA_W -: DATA_W])
                  + CSUM_W'(w_rd_data[w_mid_idx][PIX_W-1-ch*DATA_W -: DATA_W])
                  + CSUM_W'(w_rd_data[w_bot_idx][PIX_W-1-ch*DATA_W -: DATA_W]);
      end
    end
  end

  // Sliding window of column sums; cleared at row start so column -1 reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_win <= '0;
    else if (w_start)                          r_win <= '0;
    else if (r_state == RD_ROW && r_ph == 2'd1) r_win <= {w_col, r_win[2], r_win[1]};
  end

  // Window sum and exact divide by 9 per channel
  always_comb begin
    w_sum = '0;
    w_q   = '0;
    for (int ch = 0; ch < 3; ch++) begin
      w_sum[ch] = WSUM_W'(r_win[0][ch]) + WSUM_W'(r_win[1][ch]) + WSUM_W'(r_win[2][ch]);
      w_q[ch]   = DATA_W'(w_sum[ch] / WSUM_W'(9));
    end
  end

  // Byte serializer: R on load, then G and B; loads arrive every 3 cycles so no gaps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outData      <= '0;
      outDataValid <= 1'b0;
      r_ser        <= '0;
      r_ser_left   <= '0;
    end else if (w_load) begin
      outData      <= w_q[0];
      outDataValid <= 1'b1;
      r_ser        <= {w_q[1], w_q[2]};
      r_ser_left   <= 2'd2;
    end else if (r_ser_left != 2'd0) begin
      outData      <= r_ser[2*DATA_W-1 -: DATA_W];
      outDataValid <= 1'b1;
      r_ser        <= {r_ser[DATA_W-1:0], {DATA_W{1'b0}}};
      r_ser_left   <= r_ser_left - 2'd1;
    end else begin
      outData      <= '0;
      outDataValid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_blur3x3_rgb_stream.sv
`timescale 1ns/1ps
// Bench for the 3x3 RGB blur on a reduced frame; reference computes each
// output byte directly from the stored image with zero borders.
module tb_blur3x3_rgb_stream;
  localparam int TW = 12;
  localparam int TH = 12;
  localparam int RB = 3 * TW;
  localparam int FB = RB * TH;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dR, dG, dB;
  logic       dV;
  logic [7:0] outData;
  logic       outDataValid;
  logic       intr;

  logic [23:0] img [TH+1][TW];
  int got[$];
  int stamp[$];
  int ib[$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int t_l1 = 0;

  blur3x3_rgb_stream #(.IMG_W(TW), .IMG_H(TH)) dut (
    .clk          (clk),
    .reset        (reset),
    .imgDataR     (dR),
    .imgDataG     (dG),
    .imgDataB     (dB),
    .imgDataValid (dV),
    .outData      (outData),
    .outDataValid (outDataValid),
    .intr         (intr)
  );

  always #5 clk = ~clk;

  // Capture stream bytes with cycle stamps, and byte count at each intr
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (outDataValid) begin
      got.push_back(int'(outData));
      stamp.push_back(cyc);
    end
    if (intr) ib.push_back(got.size());
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_byte(input int r, input int c, input int ch);
    int s = 0;
    logic [23:0] p;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr;
        int cc = c + dc;
        if (rr >= 0 && rr < TH && cc >= 0 && cc < TW) begin
          p = img[rr][cc];
          s += int'((p >> (8 * (2 - ch))) & 24'h0000FF);
        end
      end
    return s / 9;
  endfunction

  function automatic int gb(input int base, input int r, input int c, input int ch);
    int i = base + (r * TW + c) * 3 + ch;
    return (i < got.size()) ? got[i] : -1;
  endfunction

  // mode 0: constant v on all channels, 1: random, 2: all zero
  task automatic fill(input int mode, input int v);
    logic [7:0] b;
    b = v[7:0];
    for (int r = 0; r <= TH; r++)
      for (int c = 0; c < TW; c++) begin
        if (r == TH)        img[r][c] = '0;
        else if (mode == 0) img[r][c] = {b, b, b};
        else if (mode == 1) img[r][c] = 24'($urandom);
        else                img[r][c] = '0;
      end
  endtask

  task automatic send_line(input int k, input bit gap);
    for (int c = 0; c < TW; c++) begin
      @(posedge clk); #1;
      dV = 1'b1;
      {dR, dG, dB} = img[k][c];
      if (gap) begin
        @(posedge clk); #1;
        dV = 1'b0;
      end
    end
    @(posedge clk); #1;
    dV = 1'b0;
  endtask

  task automatic feed_frame(input bit gap, input int ibase);
    int n;
    for (int k = 0; k < 4; k++) begin
      send_line(k, gap);
      if (k == 1) t_l1 = cyc;
    end
    for (int k = 4; k <= TH; k++) begin
      n = 0;
      while (ib.size() - ibase < k - 3 && n < 8 * RB) begin
        @(negedge clk);
        n++;
      end
      if (ib.size() - ibase < k - 3) begin
        chk($sformatf("feed wait intr line %0d", k), ib.size() - ibase, k - 3);
        return;
      end
      send_line(k, 1'b0);
    end
  endtask

  task automatic wait_bytes(input int target, input string nm);
    int n = 0;
    while (got.size() < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " bytes reached"}, int'(got.size() >= target), 1);
  endtask

  task automatic check_frame(input int base, input int ibase, input string nm);
    chk({nm, " byte count"}, got.size() - base, FB);
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++)
        for (int ch = 0; ch < 3; ch++)
          chk($sformatf("%s r%0d c%0d ch%0d", nm, r, c, ch), gb(base, r, c, ch), exp_byte(r, c, ch));
    for (int r = 0; r < TH; r++)
      if (base + (r + 1) * RB <= stamp.size())
        chk($sformatf("%s row %0d contiguous", nm, r),
            stamp[base + (r + 1) * RB - 1] - stamp[base + r * RB], RB - 1);
    chk({nm, " intr count"}, ib.size() - ibase, TH - 1);
    for (int k = 1; k < TH && ibase + k - 1 < ib.size(); k++)
      chk($sformatf("%s intr %0d position", nm, k), ib[ibase + k - 1] - base, (k + 1) * RB);
  endtask

  task automatic run_frame(input bit gap, input string nm, output int base);
    int ibase;
    base  = got.size();
    ibase = ib.size();
    feed_frame(gap, ibase);
    wait_bytes(base + FB, nm);
    repeat (12) @(negedge clk);
    if (!gap && got.size() > base)
      chk({nm, " row0 latency le 8"}, int'(stamp[base] - t_l1 <= 8 && stamp[base] > t_l1), 1);
    check_frame(base, ibase, nm);
  endtask

  initial begin
    int b, ba, bb, ibase;
    reset = 1'b0;
    dV = 1'b0;
    {dR, dG, dB} = '0;
    repeat (3) @(negedge clk);
    chk("reset outData", outData, 0);
    chk("reset outDataValid", outDataValid, 0);
    chk("reset intr", intr, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Uniform 90: interior 90, edges 60, corners 40
    fill(0, 90);
    run_frame(1'b0, "uniform", b);
    chk("uniform interior", gb(b, 5, 5, 1), 90);
    chk("uniform top edge", gb(b, 0, 5, 0), 60);
    chk("uniform left edge", gb(b, 5, 0, 2), 60);
    chk("uniform corner tl", gb(b, 0, 0, 0), 40);
    chk("uniform corner br", gb(b, TH - 1, TW - 1, 2), 40);

    // Impulse at (5,5) red
    fill(2, 0);
    img[5][5] = 24'hFF0000;
    run_frame(1'b0, "impulse", b);
    chk("impulse r4 c4 R", gb(b, 4, 4, 0), 28);
    chk("impulse r6 c6 R", gb(b, 6, 6, 0), 28);
    chk("impulse r5 c5 G", gb(b, 5, 5, 1), 0);
    chk("impulse r3 c5 R", gb(b, 3, 5, 0), 0);

    // Random image, gapless then gapped first lines: streams must match
    fill(1, 0);
    run_frame(1'b0, "random", ba);
    run_frame(1'b1, "gapped", bb);
    for (int i = 0; i < FB && bb + i < got.size(); i++)
      chk($sformatf("gapped vs gapless byte %0d", i), got[bb + i], got[ba + i]);

    // Abort in the middle of row 10, then a fresh constant frame
    fill(1, 0);
    b = got.size();
    ibase = ib.size();
    feed_frame(1'b0, ibase);
    wait_bytes(b + 10 * RB + TW, "pre-abort");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid reset outDataValid", outDataValid, 0);
      chk("mid reset intr", intr, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    fill(0, 200);
    run_frame(1'b0, "const200", b);
    chk("const200 interior", gb(b, 6, 7, 0), 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/blur3x3_rgb_stream.md
Name: blur3x3_rgb_stream

Overview:
- Streaming RGB 3x3 box-blur engine for a 416x416 frame.
- Four line buffers receive raw pixels (one 24-bit RGB pixel per cycle when valid).
- Emits blurred pixels as a byte stream: R, G, B per pixel, one byte per cycle.
- Raises a one-cycle interrupt each time a line buffer is freed; host software/DMA uses it to push the next image line.

Parameters:
IMG_W, 416, pixels per line
IMG_H, 416, output rows per frame
DATA_W, 8, bits per colour channel
NUM_LB, 4, number of line buffers (fixed at 4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imgDataR  in  8  red channel of input pixel
imgDataG  in  8  green channel of input pixel
imgDataB  in  8  blue channel of input pixel
imgDataValid  in  1  input pixel strobe; one pixel accepted per cycle high
outData  out  8  output byte (R, G or B of a blurred pixel)
outDataValid  out  1  outData qualifier
intr  out  1  one-cycle pulse: a line buffer was freed, send next line

Behaviour:
- Reset (reset low, asynchronous) forces the following state:
  - outData=0, outDataValid=0, intr=0.
  - All line/column/row counters cleared.
  - Write buffer index 0, read state IDLE.
  - Line buffer RAM contents are don't-care.
- Input side:
  - Each cycle with imgDataValid=1 writes {R,G,B} at the write column of the current write buffer.
  - After IMG_W pixels, the column wraps to 0 and the write buffer index advances mod 4; the filled-line count increments.
  - Pixels arriving while all 4 buffers hold unconsumed lines are dropped. The host contract forbids this.
- Frame line order:
  - Host sends lines 0..3, then one line per intr.
  - The last line sent is a zero padding line, index IMG_H.
- Output rows:
  - Row r (0..IMG_H-1) uses input lines r-1, r, r+1.
  - Line -1 is a virtual all-zero line, never stored.
  - Row r starts once line r+1 is completely stored and the output path is idle.
- Read FSM states: IDLE -> ROW (3 cycles per pixel, IMG_W pixels) -> ROW_DONE -> IDLE, or -> FRAME_DONE after row IMG_H-1.
  - FRAME_DONE clears all counters and returns to IDLE, ready for a new frame.
- Filter arithmetic:
  - Per channel independently: sum of the 3x3 window (12-bit), output = floor(sum/9), 8-bit exact.
  - Columns -1 and IMG_W are zero (horizontal zero padding). Zero rows are included in the divisor, i.e. always divide by 9.
- Output stream:
  - Each row emits exactly 3*IMG_W bytes on consecutive cycles with no gaps, order R,G,B per pixel, pixels left to right.
  - First byte of a row appears no more than 8 cycles after the row start condition.
  - Frame total is 3*IMG_W*IMG_H bytes (519168).
- Interrupt:
  - intr pulses high exactly 1 cycle at completion (last byte) of row r, for every r>=1. That row no longer needs line r-1, so its buffer is freed.
  - Row 0 frees nothing and produces no pulse.
  - Pulses for rows 414 and 415 are issued and may be ignored by the host.
- Simultaneous events:
  - A write into a buffer in the same cycle its freeing intr fires is legal.
  - Reads and writes never target the same buffer concurrently.
- Reset mid-frame aborts immediately. The next frame restarts at line 0.

Decomposition:
- Shared package holds the constants IMG_W, IMG_H, DATA_W, NUM_LB, BYTES_PER_ROW = 3*IMG_W, and the read FSM state enum.
- One natural sub-module: line_buffer_rgb, a single IMG_W x 24-bit simple dual-port RAM with write-column counter and registered read.
  - Instantiated 4 times.
  - Window, divider and byte serializer stay in the top.

Test Plan:
- Uniform image, all channels 90, full frame with intr-driven line feeding:
  - Interior bytes 90, non-corner edge bytes 60, corner bytes 40.
  - Exactly 519168 valid bytes; 415 intr pulses.
- Impulse: pixel (row 5, col 5) R=255, everything else 0:
  - R bytes of rows 4..6, cols 4..6 equal 28; all other bytes 0.
- Row-0 timing: send lines 0..3 back-to-back:
  - Row 0 output begins within 8 cycles after line 1 completes.
  - 1248 contiguous valid bytes follow.
  - No intr after row 0; first intr at end of row 1.
- Gapped input: imgDataValid toggled 1/0 every cycle through lines 0..3:
  - Output bytes identical to the gapless run.
- Reset asserted mid-row 10, then a fresh frame of constant 200:
  - outDataValid/intr low during reset.
  - New frame interior bytes 200; byte count again 519168.
